ternary_weight_loader: RTL and testbench

//   Upstream stage of the ternary matrix-vector multiplier. Accepts packed
//   2-bit ternary weights one byte at a time over a valid/ready handshake.

---
 rtl/ternary_weight_loader.sv | 115 +++++++++++
 tb/tb_ternary_weight_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_weight_loader.sv
// Byte-serial loader for the ternary matrix-vector multiplier's weight bus.
// It also sequences row/en over whole frames of OutLen rows.
module ternary_weight_loader #(
  parameter int unsigned InLen    = 16,
  parameter int unsigned OutLen   = 8,
  parameter int unsigned BitWidth = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic [BitWidth-1:0]           wdata_in,
  input  logic                          wvalid_in,
  output logic                          wready_out,
  input  logic                          run_en,
  output logic [2*InLen*OutLen-1:0]     W_out,
  output logic [$clog2(OutLen)-1:0]     row_out,
  output logic                          en_out,
  output logic                          loaded_out,
  output logic                          frame_done
);

  localparam int unsigned WW     = 2 * InLen * OutLen;
  localparam int unsigned NBYTES = WW / BitWidth;
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam int unsigned RW     = $clog2(OutLen);

  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(OutLen - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic          pend_load;

  // A load requested during RUN may arrive on the wrap cycle itself.
  logic          load_req;
  assign load_req = pend_load | load_start;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      W_out      <= '0;
      row_out    <= '0;
      en_out     <= 1'b0;
      loaded_out <= 1'b0;
      wready_out <= 1'b0;
      frame_done <= 1'b0;
      byte_cnt   <= '0;
      pend_load  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            byte_cnt   <= '0;
            loaded_out <= 1'b0;
            wready_out <= 1'b1;
          end else if (loaded_out && run_en) begin
            state   <= RUN;
            row_out <= '0;
            en_out  <= 1'b1;
          end
        end

        LOAD: begin
          // Restart drops whatever byte is offered in the same cycle.
          if (load_start) begin
            byte_cnt <= '0;
          end else if (wvalid_in && wready_out) begin
            W_out[int'(byte_cnt)*BitWidth +: BitWidth] <= wdata_in;
            byte_cnt <= byte_cnt + CW'(1);
            if (byte_cnt == LAST_BYTE) begin
              loaded_out <= 1'b1;
              wready_out <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        RUN: begin
          if (load_start) pend_load <= 1'b1;
          if (row_out == LAST_ROW) begin
            frame_done <= 1'b1;
            row_out    <= '0;
            if (!run_en || load_req) begin
              en_out <= 1'b0;
              if (load_req) begin
                state      <= LOAD;
                pend_load  <= 1'b0;
                byte_cnt   <= '0;
                loaded_out <= 1'b0;
                wready_out <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            row_out <= row_out + RW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed-plus-random bench for ternary_weight_loader against a
// transaction-level model of the load/run behaviour.
module tb_ternary_weight_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_start;
  logic [7:0]   wdata_in;
  logic         wvalid_in;
  logic         wready_out;
  logic         run_en;
  logic [255:0] W_out;
  logic [2:0]   row_out;
  logic         en_out;
  logic         loaded_out;
  logic         frame_done;

  int total = 0;
  int bad   = 0;

  ternary_weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .wdata_in   (wdata_in),
    .wvalid_in  (wvalid_in),
    .wready_out (wready_out),
    .run_en     (run_en),
    .W_out      (W_out),
    .row_out    (row_out),
    .en_out     (en_out),
    .loaded_out (loaded_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: weights as a byte array, activity as a coarse mode.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;
  int         m_mode;
  logic [7:0] m_w [32];
  int         m_cnt;
  int         m_row;
  bit         m_loaded, m_en, m_ready, m_fd, m_pend;

  function automatic logic [255:0] m_bus();
    logic [255:0] b;
    for (int i = 0; i < 32; i++) b[i*8 +: 8] = m_w[i];
    return b;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_row = 0;
    m_loaded = 0; m_en = 0; m_ready = 0; m_fd = 0; m_pend = 0;
    for (int i = 0; i < 32; i++) m_w[i] = 8'h00;
  endtask

  task automatic enter_load();
    m_mode = M_LOAD; m_cnt = 0; m_loaded = 0; m_ready = 1; m_pend = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit wrap;
    m_fd = 0;
    if (m_mode == M_IDLE) begin
      if (load_start) enter_load();
      else if (m_loaded && run_en) begin
        m_mode = M_RUN; m_row = 0; m_en = 1;
      end
    end else if (m_mode == M_LOAD) begin
      if (load_start) m_cnt = 0;
      else if (wvalid_in) begin
        m_w[m_cnt] = wdata_in;
        m_cnt++;
        if (m_cnt == 32) begin
          m_loaded = 1; m_ready = 0; m_mode = M_IDLE;
        end
      end
    end else begin
      wrap = (m_row == 7);
      m_row = (m_row + 1) % 8;
      m_pend = m_pend | load_start;
      if (wrap) begin
        m_fd = 1;
        if (m_pend) begin
          m_en = 0; enter_load();
        end else if (!run_en) begin
          m_en = 0; m_mode = M_IDLE;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".W"},      W_out,              m_bus());
    check({tag, ".row"},    256'(row_out),      256'(m_row));
    check({tag, ".en"},     256'(en_out),       256'(m_en));
    check({tag, ".loaded"}, 256'(loaded_out),   256'(m_loaded));
    check({tag, ".ready"},  256'(wready_out),   256'(m_ready));
    check({tag, ".fd"},     256'(frame_done),   256'(m_fd));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    load_start = 0; wvalid_in = 0; wdata_in = 8'h00;
  endtask

  task automatic pulse_load(input string tag);
    load_start = 1; tick(tag); load_start = 0;
  endtask

  // Offer n bytes with random idle gaps; data from $urandom unless fixed.
  task automatic send_bytes(input int n, input bit use_idx, input int base, input string tag);
    for (int i = 0; i < n; i++) begin
      if (!use_idx) begin
        while ($urandom_range(3) == 0) begin
          wvalid_in = 0; wdata_in = 8'($urandom); tick({tag, ".gap"});
        end
      end
      wvalid_in = 1;
      wdata_in  = use_idx ? 8'(base + i) : 8'($urandom);
      tick(tag);
    end
    wvalid_in = 0;
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    compare_all(tag);
    check({tag, ".w0"}, W_out, '0);
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    tick({tag, ".rel"});
  endtask

  logic [255:0] w_snap;

  initial begin
    rst_n = 0; run_en = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;
    tick("post_reset");

    // 1: incrementing load
    pulse_load("t1.start");
    send_bytes(32, 1, 0, "t1.byte");
    check("t1.w_lo", 256'(W_out[7:0]), 256'(8'h00));
    check("t1.w_hi", 256'(W_out[255:248]), 256'(8'h1F));
    check("t1.loaded", 256'(loaded_out), 256'(1'b1));
    check("t1.ready", 256'(wready_out), 256'(1'b0));
    tick("t1.idle");

    // 2: continuous run, random wvalid noise must not write
    run_en = 1;
    for (int i = 0; i < 20; i++) begin
      wvalid_in = 1'($urandom); wdata_in = 8'($urandom);
      tick("t2.run");
    end
    idle_inputs();

    // 3: drop run_en at row 3, frame completes
    for (int i = 0; i < 10 && m_row != 3; i++) tick("t3.seek");
    run_en = 0;
    for (int i = 0; i < 12 && m_mode != M_IDLE; i++) tick("t3.drain");
    check("t3.row0", 256'(row_out), '0);
    check("t3.en0", 256'(en_out), '0);
    tick("t3.idle");

    // 4: load request at row 2 while running
    run_en = 1;
    for (int i = 0; i < 12 && !(m_mode == M_RUN && m_row == 2); i++) tick("t4.seek");
    w_snap = W_out;
    pulse_load("t4.req");
    for (int i = 0; i < 12 && m_mode != M_LOAD; i++) tick("t4.drain");
    run_en = 0;
    check("t4.ready", 256'(wready_out), 256'(1'b1));
    check("t4.frozen", W_out, w_snap);
    tick("t4.wait");

    // 5: restart after 10 bytes drops the concurrent byte
    send_bytes(10, 0, 0, "t5.byte");
    load_start = 1; wvalid_in = 1; wdata_in = 8'hAA;
    tick("t5.restart");
    load_start = 0;
    wdata_in = 8'h55;
    tick("t5.b55");
    wvalid_in = 0;
    check("t5.w0", 256'(W_out[7:0]), 256'(8'h55));
    check("t5.loaded", 256'(loaded_out), 256'(1'b0));
    send_bytes(31, 0, 0, "t5.rest");
    tick("t5.done");

    // 6a: reset in the middle of a load
    pulse_load("t6.start");
    send_bytes(17, 0, 0, "t6.byte");
    async_reset("t6.rst_load");

    // 6b: reset while running at row 5
    pulse_load("t6.start2");
    send_bytes(32, 0, 0, "t6.byte2");
    run_en = 1;
    for (int i = 0; i < 12 && !(m_mode == M_RUN && m_row == 5); i++) tick("t6.seek");
    async_reset("t6.rst_run");
    run_en = 0;
    tick("t6.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
